// File: rtl/ysyx_22040632_axi_pkg.sv
// Shared AXI constants, FSM state type and the narrow-read lane alignment helper
// used by the imem read bridge.
package ysyx_22040632_axi_pkg;

  localparam int AXI_DATA_W = 64;
  localparam int AXI_ID_W   = 4;

  localparam logic [2:0] AXI_SIZE_BYTES_4 = 3'd2;
  localparam logic [2:0] AXI_SIZE_BYTES_8 = 3'd3;
  localparam logic       REQ_READ         = 1'b0;
  localparam logic       REQ_WRITE        = 1'b1;
  localparam logic [1:0] BURST_INCR       = 2'b01;
  localparam logic [1:0] RESP_OKAY        = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    RD   = 2'd2,
    GAP  = 2'd3
  } imem_axi_state_e;

  // Narrow transfers arrive on their byte lanes; move them down to bit 0.
  function automatic logic [AXI_DATA_W-1:0] lane_align(
    input logic [AXI_DATA_W-1:0] data,
    input logic [2:0]            addr_lo,
    input logic [2:0]            size
  );
    if (size < AXI_SIZE_BYTES_8) lane_align = data >> {addr_lo, 3'b000};
    else                         lane_align = data;
  endfunction

endpackage

// File: rtl/ysyx_22040632_imem_axi_bridge.sv
// AXI4 read master for the icache imif port: one request becomes one AR
// transaction and its R beats, delivered as data_read/r_hs. Write channels tied off.
module ysyx_22040632_imem_axi_bridge
  import ysyx_22040632_axi_pkg::*;
#(
  parameter int                  ADDR_W = 32,
  parameter int                  DATA_W = AXI_DATA_W,
  parameter int                  LEN_W  = 8,
  parameter logic [AXI_ID_W-1:0] AXI_ID = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rw_valid,
  input  logic                rw_req,
  input  logic [ADDR_W-1:0]   rw_addr,
  input  logic [LEN_W-1:0]    rw_len,
  input  logic [2:0]          rw_size,
  output logic                rw_ready,
  output logic [DATA_W-1:0]   data_read,
  output logic                r_hs,
  output logic                r_last,
  output logic                rd_err,
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [AXI_ID_W-1:0] ar_id,
  output logic [LEN_W-1:0]    ar_len,
  output logic [2:0]          ar_size,
  output logic [1:0]          ar_burst,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          r_resp,
  input  logic                r_last_i,
  input  logic [AXI_ID_W-1:0] r_id,
  output logic                aw_valid,
  output logic                w_valid,
  output logic                b_ready,
  output imem_axi_state_e     dbg_state
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready
  // are both high; ar_* stay stable from ar_valid rise until that edge.

  imem_axi_state_e   state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              ar_valid_q, ar_valid_d;
  logic              rd_err_q, rd_err_d;

  logic id_match;
  logic beat;
  logic cnt_at_len;
  logic final_beat;

  assign id_match   = (r_id == AXI_ID);
  assign r_ready    = (state_q == RD) && id_match;
  assign beat       = r_valid && r_ready;
  assign cnt_at_len = (cnt_q == len_q);
  // A premature RLAST still terminates the burst so the icache is never stranded.
  assign final_beat = beat && (cnt_at_len || r_last_i);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    ar_valid_d = ar_valid_q;
    rd_err_d   = rd_err_q;
    case (state_q)
      IDLE: begin
        if (rw_valid && (rw_req == REQ_READ)) begin
          addr_d     = rw_addr;
          len_d      = rw_len;
          size_d     = rw_size;
          cnt_d      = '0;
          ar_valid_d = 1'b1;
          state_d    = AR;
        end
      end
      AR: begin
        if (ar_ready) begin
          ar_valid_d = 1'b0;
          state_d    = RD;
        end
      end
      RD: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if ((r_resp != RESP_OKAY) || (r_last_i != cnt_at_len)) rd_err_d = 1'b1;
          if (final_beat) state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      cnt_q      <= '0;
      ar_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      cnt_q      <= cnt_d;
      ar_valid_q <= ar_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign ar_valid  = ar_valid_q;
  assign ar_addr   = addr_q;
  assign ar_len    = len_q;
  assign ar_size   = size_q;
  assign ar_id     = AXI_ID;
  assign ar_burst  = BURST_INCR;

  assign r_hs      = beat;
  assign r_last    = final_beat;
  assign rw_ready  = final_beat;
  assign data_read = beat ? lane_align(r_data, addr_q[2:0], size_q) : '0;
  assign rd_err    = rd_err_q;

  assign aw_valid  = 1'b0;
  assign w_valid   = 1'b0;
  assign b_ready   = 1'b0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ysyx_22040632_imem_axi_bridge.sv
// Bench for the imem AXI read bridge: the bench plays the icache and the AXI slave,
// and predicts each delivered beat from the request and the slave's data.
module tb_ysyx_22040632_imem_axi_bridge;
  import ysyx_22040632_axi_pkg::*;

  logic        clk, rst;
  logic        rw_valid, rw_req;
  logic [31:0] rw_addr;
  logic [7:0]  rw_len;
  logic [2:0]  rw_size;
  logic        rw_ready;
  logic [63:0] data_read;
  logic        r_hs, r_last, rd_err;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last_i;
  logic [3:0]  r_id;
  logic        aw_valid, w_valid, b_ready;
  imem_axi_state_e dbg_state;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  ysyx_22040632_imem_axi_bridge dut (
    .clk(clk), .rst(rst),
    .rw_valid(rw_valid), .rw_req(rw_req), .rw_addr(rw_addr), .rw_len(rw_len),
    .rw_size(rw_size), .rw_ready(rw_ready), .data_read(data_read),
    .r_hs(r_hs), .r_last(r_last), .rd_err(rd_err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .r_last_i(r_last_i), .r_id(r_id),
    .aw_valid(aw_valid), .w_valid(w_valid), .b_ready(b_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input bit hold);
    rw_valid = 1'b1;
    rw_req   = REQ_READ;
    rw_addr  = addr;
    rw_len   = len;
    rw_size  = size;
    next_cycle();
    if (!hold) rw_valid = 1'b0;
  endtask

  // Waits for ar_valid, leaves ar_ready low for 'stall' further cycles, then accepts.
  task automatic serve_ar(input int stall, output logic seen, output logic stable,
                          output int hs_early, output logic [31:0] a,
                          output logic [7:0] l, output logic [2:0] s);
    int waited;
    waited = 0;
    seen = 1'b0; stable = 1'b1; hs_early = 0; a = '0; l = '0; s = '0;
    @(negedge clk);
    while (ar_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (ar_valid !== 1'b1) return;
    seen = 1'b1; a = ar_addr; l = ar_len; s = ar_size;
    if (r_hs !== 1'b0) hs_early++;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (ar_valid !== 1'b1 || ar_addr !== a || ar_len !== l || ar_size !== s) stable = 1'b0;
      if (r_hs !== 1'b0) hs_early++;
    end
    ar_ready = 1'b1;
    @(posedge clk);
    #1;
    ar_ready = 1'b0;
  endtask

  // Presents one R beat after 'gap' idle cycles and reports what the bridge showed.
  task automatic serve_beat(input logic [63:0] data, input logic [1:0] resp, input bit last,
                            input int gap, output logic hs, output logic [63:0] dr,
                            output logic rl, output logic rwr, output int stray);
    stray = 0;
    r_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (r_hs !== 1'b0 || rw_ready !== 1'b0 || r_last !== 1'b0) stray++;
      next_cycle();
    end
    r_valid  = 1'b1;
    r_data   = data;
    r_resp   = resp;
    r_last_i = last;
    r_id     = 4'd0;
    @(negedge clk);
    hs = r_hs; dr = data_read; rl = r_last; rwr = rw_ready;
    next_cycle();
    r_valid  = 1'b0;
    r_last_i = 1'b0;
    r_resp   = 2'd0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (rw_ready !== 1'b0 || r_hs !== 1'b0 || r_last !== 1'b0) begin errors++; $display("FAIL reset_pulses: rw_ready=%b r_hs=%b r_last=%b want 000", rw_ready, r_hs, r_last); end
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got=%0d want=%0d", dbg_state, IDLE); end
    checks++; if (ar_valid !== 1'b0) begin errors++; $display("FAIL reset_ar_valid: got=%b want=0", ar_valid); end
    checks++; if (r_ready !== 1'b0) begin errors++; $display("FAIL reset_r_ready: got=%b want=0", r_ready); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err: got=%b want=0", rd_err); end
    checks++; if (data_read !== 64'd0) begin errors++; $display("FAIL reset_data_read: got=%h want=0", data_read); end
    checks++; if (ar_addr !== 32'd0 || ar_len !== 8'd0 || ar_size !== 3'd0) begin errors++; $display("FAIL reset_latched: addr=%h len=%h size=%h want 0", ar_addr, ar_len, ar_size); end
    checks++; if ({aw_valid, w_valid, b_ready} !== 3'b000) begin errors++; $display("FAIL tie_offs: got=%b want=000", {aw_valid, w_valid, b_ready}); end
    checks++; if (ar_burst !== 2'b01 || ar_id !== 4'd0) begin errors++; $display("FAIL ar_const: burst=%b id=%h want 01/0", ar_burst, ar_id); end
    next_cycle();
  endtask

  task automatic test_uncached();
    logic seen, stable, hs, rl, rwr;
    int early, stray, ar_hi;
    logic [31:0] a, addr;
    logic [7:0] l;
    logic [2:0] s, size;
    logic [63:0] dr, data, exp;
    // write requests must never start a transaction
    ar_hi = 0;
    rw_valid = 1'b1; rw_req = REQ_WRITE; rw_addr = 32'h8000_1000; rw_len = 8'd0; rw_size = 3'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ar_valid !== 1'b0) ar_hi++;
      next_cycle();
    end
    rw_valid = 1'b0;
    checks++; if (ar_hi !== 0) begin errors++; $display("FAIL write_ignored: ar_valid high %0d cycles want 0", ar_hi); end

    send_req(32'h8000_0004, 8'd0, 3'd2, 1'b0);
    serve_ar(0, seen, stable, early, a, l, s);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL uc_ar_seen: got=%b want=1", seen); end
    checks++; if (a !== 32'h8000_0004) begin errors++; $display("FAIL uc_ar_addr: got=%h want=80000004", a); end
    checks++; if (l !== 8'd0 || s !== 3'd2) begin errors++; $display("FAIL uc_ar_len_size: len=%h size=%h want 0/2", l, s); end
    serve_beat(64'h1111_2222_3333_4444, 2'd0, 1'b1, 0, hs, dr, rl, rwr, stray);
    checks++; if (dr !== 64'h0000_0000_1111_2222) begin errors++; $display("FAIL uc_data: got=%h want=0000000011112222", dr); end
    checks++; if ({hs, rl, rwr} !== 3'b111) begin errors++; $display("FAIL uc_flags: hs/last/rw_ready=%b want 111", {hs, rl, rwr}); end
    next_cycle();

    for (int k = 0; k < 6; k++) begin
      size = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3;
      addr = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
      if (size == 3'd3) addr = addr & ~32'h7;
      data = {$urandom, $urandom};
      exp  = (size == 3'd2) ? (data >> (8 * (addr % 8))) : data;
      send_req(addr, 8'd0, size, 1'b0);
      serve_ar($urandom_range(0, 2), seen, stable, early, a, l, s);
      checks++; if (a !== addr) begin errors++; $display("FAIL rnd_ar_addr: got=%h want=%h", a, addr); end
      serve_beat(data, 2'd0, 1'b1, $urandom_range(0, 2), hs, dr, rl, rwr, stray);
      checks++; if (dr !== exp || rwr !== 1'b1 || stray !== 0) begin errors++; $display("FAIL rnd_beat: data=%h want=%h rw_ready=%b stray=%0d", dr, exp, rwr, stray); end
      next_cycle();
    end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL uc_rd_err: got=%b want=0", rd_err); end
  endtask

  task automatic test_refill();
    logic seen, stable, hs, rl, rwr;
    int early, stray, hs_n, bad_last, stray_tot;
    logic [31:0] a;
    logic [7:0] l;
    logic [2:0] s;
    logic [63:0] dr, exp;
    logic [63:0] d [8];
    hs_n = 0; bad_last = 0; stray_tot = 0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      d[i] = {$urandom, $urandom};
      exp_q.push_back(d[i]);
    end
    send_req(32'h8000_0040, 8'd7, 3'd3, 1'b0);
    serve_ar(0, seen, stable, early, a, l, s);
    checks++; if (a !== 32'h8000_0040 || l !== 8'd7 || s !== 3'd3) begin errors++; $display("FAIL refill_ar: addr=%h len=%h size=%h want 80000040/7/3", a, l, s); end
    for (int b = 0; b < 8; b++) begin
      if (b == 3) begin
        r_valid = 1'b1; r_id = 4'd5; r_data = '1; r_last_i = 1'b0;
        @(negedge clk);
        checks++; if (r_ready !== 1'b0 || r_hs !== 1'b0) begin errors++; $display("FAIL refill_foreign_id: r_ready=%b r_hs=%b want 0/0", r_ready, r_hs); end
        next_cycle();
        r_valid = 1'b0;
      end
      serve_beat(d[b], 2'd0, (b == 7), $urandom_range(0, 3), hs, dr, rl, rwr, stray);
      stray_tot += stray;
      if (hs === 1'b1 && exp_q.size() > 0) begin
        hs_n++;
        exp = exp_q.pop_front();
        checks++; if (dr !== exp) begin errors++; $display("FAIL refill_data beat %0d: got=%h want=%h", b, dr, exp); end
      end
      if ((rl !== 1'b0 || rwr !== 1'b0) && b != 7) bad_last++;
      if (b == 7) begin
        checks++; if (rl !== 1'b1 || rwr !== 1'b1) begin errors++; $display("FAIL refill_final: r_last=%b rw_ready=%b want 1/1", rl, rwr); end
      end
    end
    checks++; if (hs_n !== 8) begin errors++; $display("FAIL refill_hs_count: got=%0d want=8", hs_n); end
    checks++; if (bad_last !== 0 || stray_tot !== 0) begin errors++; $display("FAIL refill_early_flags: early_last=%0d stray=%0d want 0/0", bad_last, stray_tot); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL refill_sb_left: got=%0d want=0", exp_q.size()); end
    checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL refill_rd_err: got=%b want=0", rd_err); end
    next_cycle();
  endtask

  task automatic test_ar_backpressure();
    logic seen, stable, hs, rl, rwr;
    int early, stray;
    logic [31:0] a;
    logic [7:0] l;
    logic [2:0] s;
    logic [63:0] dr, data;
    data = {$urandom, $urandom};
    send_req(32'h8000_0104, 8'd0, 3'd2, 1'b0);
    // the slave already offers a beat; it must not be taken before AR completes
    r_valid = 1'b1; r_id = 4'd0; r_data = data; r_last_i = 1'b1; r_resp = 2'd0;
    serve_ar(4, seen, stable, early, a, l, s);
    checks++; if (seen !== 1'b1 || stable !== 1'b1) begin errors++; $display("FAIL bp_ar_stable: seen=%b stable=%b want 1/1", seen, stable); end
    checks++; if (a !== 32'h8000_0104) begin errors++; $display("FAIL bp_ar_addr: got=%h want=80000104", a); end
    checks++; if (early !== 0) begin errors++; $display("FAIL bp_early_hs: got=%0d want=0", early); end
    serve_beat(data, 2'd0, 1'b1, 0, hs, dr, rl, rwr, stray);
    checks++; if (dr !== (data >> 32) || rwr !== 1'b1) begin errors++; $display("FAIL bp_beat: data=%h want=%h rw_ready=%b", dr, data >> 32, rwr); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic seen, stable, hs, rl, rwr;
    int early, stray, k;
    logic [31:0] a;
    logic [7:0] l;
    logic [2:0] s;
    logic [63:0] dr, d1, d2;
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    send_req(32'h8000_0200, 8'd0, 3'd3, 1'b1);
    serve_ar(0, seen, stable, early, a, l, s);
    serve_beat(d1, 2'd0, 1'b1, 0, hs, dr, rl, rwr, stray);
    checks++; if (rwr !== 1'b1 || dr !== d1) begin errors++; $display("FAIL b2b_first: rw_ready=%b data=%h want 1/%h", rwr, dr, d1); end
    rw_addr = 32'h8000_0208;
    // two dead cycles follow the final beat before the next AR can appear
    k = 0;
    while (k < 10) begin
      @(negedge clk);
      k++;
      if (ar_valid === 1'b1) break;
    end
    checks++; if (k !== 3) begin errors++; $display("FAIL b2b_ar_timing: ar_valid in cycle %0d after rw_ready want 3", k); end
    checks++; if (ar_addr !== 32'h8000_0208) begin errors++; $display("FAIL b2b_ar_addr: got=%h want=80000208", ar_addr); end
    rw_valid = 1'b0;
    ar_ready = 1'b1;
    next_cycle();
    ar_ready = 1'b0;
    serve_beat(d2, 2'd0, 1'b1, 1, hs, dr, rl, rwr, stray);
    checks++; if (rwr !== 1'b1 || dr !== d2) begin errors++; $display("FAIL b2b_second: rw_ready=%b data=%h want 1/%h", rwr, dr, d2); end
    next_cycle();
  endtask

  task automatic test_errors();
    logic seen, stable, hs, rl, rwr, done;
    int early, stray, hs_n, end_beat, late_hs;
    logic [31:0] a;
    logic [7:0] l;
    logic [2:0] s;
    logic [63:0] dr, data;
    hs_n = 0; done = 1'b0; end_beat = -1; late_hs = 0;
    send_req(32'h8000_0300, 8'd7, 3'd3, 1'b0);
    serve_ar(0, seen, stable, early, a, l, s);
    for (int b = 0; b < 8 && !done; b++) begin
      if (b == 2) begin
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL err_before_resp: rd_err=%b want 0", rd_err); end
      end
      if (b == 3) begin
        checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL err_after_resp: rd_err=%b want 1", rd_err); end
      end
      data = {$urandom, $urandom};
      serve_beat(data, (b == 2) ? 2'd2 : 2'd0, (b == 4), $urandom_range(0, 2), hs, dr, rl, rwr, stray);
      if (hs === 1'b1) hs_n++;
      checks++; if (dr !== data) begin errors++; $display("FAIL err_data beat %0d: got=%h want=%h", b, dr, data); end
      if (rwr === 1'b1) begin
        done = 1'b1;
        end_beat = b;
        checks++; if (rl !== 1'b1) begin errors++; $display("FAIL err_r_last: got=%b want=1", rl); end
      end
    end
    checks++; if (end_beat !== 4 || hs_n !== 5) begin errors++; $display("FAIL err_early_last: ended on beat %0d after %0d beats want 4/5", end_beat, hs_n); end
    r_valid = 1'b1; r_id = 4'd0; r_data = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (r_hs !== 1'b0 || r_ready !== 1'b0) late_hs++;
      next_cycle();
    end
    r_valid = 1'b0;
    checks++; if (late_hs !== 0) begin errors++; $display("FAIL err_beats_after_end: got=%0d want=0", late_hs); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL err_back_idle: state=%0d want=%0d", dbg_state, IDLE); end
    checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL err_sticky: rd_err=%b want 1", rd_err); end
  endtask

  task automatic test_reset_mid();
    logic seen, stable, hs, rl, rwr;
    int early, stray;
    logic [31:0] a;
    logic [7:0] l;
    logic [2:0] s;
    logic [63:0] dr, data;
    send_req(32'h8000_0400, 8'd7, 3'd3, 1'b0);
    serve_ar(0, seen, stable, early, a, l, s);
    for (int b = 0; b < 3; b++) serve_beat({$urandom, $urandom}, 2'd0, 1'b0, 0, hs, dr, rl, rwr, stray);
    r_valid = 1'b1; r_id = 4'd0; r_data = 64'hdead_beef_0bad_f00d; r_last_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({r_hs, r_last, rw_ready, r_ready, ar_valid} !== 5'b0) begin errors++; $display("FAIL rst_mid_outputs: hs/last/rw_ready/r_ready/ar_valid=%b want 00000", {r_hs, r_last, rw_ready, r_ready, ar_valid}); end
    checks++; if (rd_err !== 1'b0 || data_read !== 64'd0) begin errors++; $display("FAIL rst_mid_err_data: rd_err=%b data=%h want 0/0", rd_err, data_read); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_mid_state: got=%0d want=%0d", dbg_state, IDLE); end
    r_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();

    data = {$urandom, $urandom};
    send_req(32'h8000_000c, 8'd0, 3'd2, 1'b0);
    serve_ar(1, seen, stable, early, a, l, s);
    checks++; if (a !== 32'h8000_000c) begin errors++; $display("FAIL post_rst_ar_addr: got=%h want=8000000c", a); end
    serve_beat(data, 2'd0, 1'b1, 0, hs, dr, rl, rwr, stray);
    checks++; if (dr !== (data >> 32) || rwr !== 1'b1 || rd_err !== 1'b0) begin errors++; $display("FAIL post_rst_beat: data=%h want=%h rw_ready=%b rd_err=%b", dr, data >> 32, rwr, rd_err); end
    next_cycle();

    // final beat without RLAST still ends the transfer but flags an error
    data = {$urandom, $urandom};
    send_req(32'h8000_0010, 8'd0, 3'd3, 1'b0);
    serve_ar(0, seen, stable, early, a, l, s);
    serve_beat(data, 2'd0, 1'b0, 0, hs, dr, rl, rwr, stray);
    checks++; if (rwr !== 1'b1 || rl !== 1'b1 || dr !== data) begin errors++; $display("FAIL missing_last_end: rw_ready=%b r_last=%b data=%h want 1/1/%h", rwr, rl, dr, data); end
    @(negedge clk);
    checks++; if (rd_err !== 1'b1) begin errors++; $display("FAIL missing_last_err: rd_err=%b want 1", rd_err); end
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    rw_valid = 1'b0; rw_req = REQ_READ; rw_addr = '0; rw_len = '0; rw_size = '0;
    ar_ready = 1'b0;
    r_valid = 1'b0; r_data = '0; r_resp = '0; r_last_i = 1'b0; r_id = '0;
    test_reset();
    test_uncached();
    test_refill();
    test_ar_backpressure();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
